// File: rtl/mic_frame_aligner_if.sv
// Bundles the microphone capture inputs and the frame stream toward the DSP
// stages of mic_frame_aligner; slave is the aligner's view, master the driver's.
interface mic_frame_aligner_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  logic [2:0]               chan_en;
  logic [2:0]               valid_in;
  logic [WIDTH-1:0]         sample_in_0;
  logic [WIDTH-1:0]         sample_in_1;
  logic [WIDTH-1:0]         sample_in_2;
  logic [3*WIDTH-1:0]       frame_out;
  logic [2:0]               frame_missing_out;
  logic                     valid_out;
  logic                     ready_in;
  logic [$clog2(DEPTH):0]   fill_level;
  logic [15:0]              overflow_count;

  modport slave (
    input  chan_en, valid_in, sample_in_0, sample_in_1, sample_in_2, ready_in,
    output frame_out, frame_missing_out, valid_out, fill_level, overflow_count
  );

  modport master (
    output chan_en, valid_in, sample_in_0, sample_in_1, sample_in_2, ready_in,
    input  frame_out, frame_missing_out, valid_out, fill_level, overflow_count
  );
endinterface

// File: rtl/mic_frame_aligner.sv
// Groups one sample per enabled I2S microphone into a frame and queues frames in a
// first-word fall-through FIFO. Define MIC_ALIGN_TIMEOUT_EN to emit partial frames on timeout.
module mic_frame_aligner #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk_in,
  input  logic              rst_in,
  mic_frame_aligner_if.slave bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] PUSH    = 2'd2;

  localparam int            AW       = $clog2(DEPTH);
  localparam int            FW       = 3 * WIDTH + 3;
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [2:0]       pending;
  logic [2:0]       pend_acc;
  logic [2:0]       capture;
  logic [2:0]       missing_r;
  logic             complete;
  logic             timeout_hit;
  logic [WIDTH-1:0] sample [3];
  logic [WIDTH-1:0] hold   [3];
  logic [FW-1:0]    push_word;

  logic [FW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [15:0]      overflow;
  logic [FW-1:0]    head;
  logic             push_req;
  logic             push_ok;
  logic             pop;
  logic             full;
  logic             drop;

  assign sample[0] = bus.sample_in_0;
  assign sample[1] = bus.sample_in_1;
  assign sample[2] = bus.sample_in_2;

  assign capture  = bus.valid_in & bus.chan_en;
  // Completion looks at this edge's captures so PUSH follows the last strobe directly.
  assign pend_acc = pending | capture;
  assign complete = ((pend_acc & bus.chan_en) == bus.chan_en) && (bus.chan_en != '0);

`ifdef MIC_ALIGN_TIMEOUT_EN
  localparam int            TW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] timer;

  assign timeout_hit = (state == COLLECT) && (timer == T_LAST);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      timer <= '0;
    end else if (state_nxt == COLLECT && state != COLLECT) begin
      timer <= '0;
    end else if (state == COLLECT) begin
      timer <= timer + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      missing_r <= '0;
    end else if (state_nxt == PUSH) begin
      missing_r <= complete ? 3'b000 : (bus.chan_en & ~pend_acc);
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign missing_r   = '0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (capture != '0) state_nxt = complete ? PUSH : COLLECT;
      COLLECT: if (complete || timeout_hit) state_nxt = PUSH;
      PUSH:    state_nxt = (capture != '0) ? COLLECT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state   <= IDLE;
      pending <= '0;
      for (int unsigned i = 0; i < 3; i++) hold[i] <= '0;
    end else begin
      state <= state_nxt;
      // Strobes landing in the PUSH cycle start the next frame instead of being cleared.
      pending <= (state == PUSH) ? capture : pend_acc;
      for (int unsigned i = 0; i < 3; i++) begin
        if (capture[i]) hold[i] <= sample[i];
      end
    end
  end

  always_comb begin
    push_word = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (pending[i]) push_word[i*WIDTH +: WIDTH] = hold[i];
    end
    push_word[3*WIDTH +: 3] = missing_r;
  end

  assign push_req = (state == PUSH);
  assign full     = (count == FULL_LVL);
  assign pop      = bus.valid_out & bus.ready_in;
  // A full FIFO still takes the frame when the head leaves on the same edge.
  assign push_ok  = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  always_ff @(posedge clk_in) begin
    if (push_ok) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop && overflow != '1) overflow <= overflow + 1'b1;
    end
  end

  assign head                  = mem[rd_ptr];
  assign bus.valid_out         = (count != '0);
  assign bus.frame_out         = bus.valid_out ? head[3*WIDTH-1:0] : '0;
  assign bus.frame_missing_out = bus.valid_out ? head[3*WIDTH +: 3] : '0;
  assign bus.fill_level        = count;
  assign bus.overflow_count    = overflow;

endmodule

// File: tb/tb_mic_frame_aligner.sv
// Directed scoreboard bench for mic_frame_aligner: expected frames are queued as
// stimulus completes them and compared when they reach the FIFO head.
module tb_mic_frame_aligner;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  logic [50:0] exp_q [$];

  always #5 clk = ~clk;

  mic_frame_aligner_if #(.WIDTH(16), .DEPTH(8)) bus ();

  mic_frame_aligner #(.WIDTH(16), .DEPTH(8), .TIMEOUT(16)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [2:0] v, input logic [15:0] s0,
                        input logic [15:0] s1, input logic [15:0] s2);
    bus.valid_in    = v;
    bus.sample_in_0 = s0;
    bus.sample_in_1 = s1;
    bus.sample_in_2 = s2;
    tick();
    bus.valid_in = 3'b000;
  endtask

  task automatic push_exp(input logic [2:0] m, input logic [15:0] c2,
                          input logic [15:0] c1, input logic [15:0] c0);
    exp_q.push_back({m, c2, c1, c0});
  endtask

  task automatic check_head(input string tag);
    logic [50:0] e;
    if (exp_q.size() == 0) e = 'x;
    else e = exp_q.pop_front();
    check({tag, "_valid"},   64'(bus.valid_out), 64'd1);
    check({tag, "_frame"},   64'(bus.frame_out), 64'(e[47:0]));
    check({tag, "_missing"}, 64'(bus.frame_missing_out), 64'(e[50:48]));
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.ready_in    = 1'b0;
    bus.chan_en     = 3'b000;
    bus.valid_in    = 3'b000;
    bus.sample_in_0 = '0;
    bus.sample_in_1 = '0;
    bus.sample_in_2 = '0;

    #12;
    check("rst_frame",   64'(bus.frame_out), 64'd0);
    check("rst_missing", 64'(bus.frame_missing_out), 64'd0);
    check("rst_valid",   64'(bus.valid_out), 64'd0);
    check("rst_fill",    64'(bus.fill_level), 64'd0);
    check("rst_ovf",     64'(bus.overflow_count), 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic alignment: strobes five cycles apart, output two edges after the last.
    bus.ready_in = 1'b1;
    bus.chan_en  = 3'b111;
    strobe(3'b001, 16'h1111, 16'h0, 16'h0);
    repeat (4) tick();
    strobe(3'b010, 16'h0, 16'h2222, 16'h0);
    repeat (4) tick();
    strobe(3'b100, 16'h0, 16'h0, 16'h3333);
    check("basic_early", 64'(bus.valid_out), 64'd0);
    push_exp(3'b000, 16'h3333, 16'h2222, 16'h1111);
    tick();
    check_head("basic");
    tick();
    check("basic_drained", 64'(bus.valid_out), 64'd0);

    // Capture during PUSH belongs to the next frame.
    bus.ready_in = 1'b0;
    bus.chan_en  = 3'b011;
    strobe(3'b001, 16'hAAAA, 16'h0, 16'h0);
    tick();
    tick();
    bus.valid_in    = 3'b010;
    bus.sample_in_1 = 16'hBBBB;
    tick();
    bus.valid_in    = 3'b001;
    bus.sample_in_0 = 16'h5555;
    tick();
    bus.valid_in    = 3'b000;
    push_exp(3'b000, 16'h0000, 16'hBBBB, 16'hAAAA);
    check("pushcap_fill1", 64'(bus.fill_level), 64'd1);
    tick();
    tick();
    strobe(3'b010, 16'h0, 16'h6666, 16'h0);
    tick();
    push_exp(3'b000, 16'h0000, 16'h6666, 16'h5555);
    check("pushcap_fill2", 64'(bus.fill_level), 64'd2);
    bus.ready_in = 1'b1;
    check_head("pushcap_n");
    tick();
    check_head("pushcap_n1");
    tick();
    bus.ready_in = 1'b0;
    check("pushcap_drained", 64'(bus.valid_out), 64'd0);

    // Overflow: ten frames into an eight-deep FIFO with no consumer.
    bus.chan_en = 3'b111;
    for (int i = 1; i <= 10; i++) begin
      strobe(3'b111, 16'h1000 + 16'(i), 16'h2000 + 16'(i), 16'h3000 + 16'(i));
      tick();
      if (i <= 8) push_exp(3'b000, 16'h3000 + 16'(i), 16'h2000 + 16'(i), 16'h1000 + 16'(i));
    end
    check("ovf_fill", 64'(bus.fill_level), 64'd8);
    check("ovf_count", 64'(bus.overflow_count), 64'd2);
    check_head("ovf_head");

    // Full FIFO with a pop on the push edge keeps the new frame.
    strobe(3'b111, 16'h1011, 16'h2011, 16'h3011);
    bus.ready_in = 1'b1;
    tick();
    bus.ready_in = 1'b0;
    push_exp(3'b000, 16'h3011, 16'h2011, 16'h1011);
    check("fullpop_fill", 64'(bus.fill_level), 64'd8);
    check("fullpop_ovf", 64'(bus.overflow_count), 64'd2);
    bus.ready_in = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check_head("drain");
      tick();
    end
    bus.ready_in = 1'b0;
    check("drain_empty", 64'(bus.valid_out), 64'd0);

`ifdef MIC_ALIGN_TIMEOUT_EN
    // Partial frame after TIMEOUT+1 edges from COLLECT entry.
    strobe(3'b001, 16'hABCD, 16'h0, 16'h0);
    tick();
    tick();
    strobe(3'b100, 16'h0, 16'h0, 16'h0F0F);
    repeat (13) tick();
    check("timeout_early", 64'(bus.valid_out), 64'd0);
    tick();
    push_exp(3'b010, 16'h0F0F, 16'h0000, 16'hABCD);
    check_head("timeout");
`else
    // Without the timeout the frame waits for the missing channel.
    strobe(3'b001, 16'hABCD, 16'h0, 16'h0);
    tick();
    tick();
    strobe(3'b100, 16'h0, 16'h0, 16'h0F0F);
    repeat (40) tick();
    check("notimeout_wait", 64'(bus.valid_out), 64'd0);
    strobe(3'b010, 16'h0, 16'h1234, 16'h0);
    tick();
    push_exp(3'b000, 16'h0F0F, 16'h1234, 16'hABCD);
    check_head("notimeout");
`endif
    bus.ready_in = 1'b1;
    tick();
    bus.ready_in = 1'b0;

    // Asynchronous reset mid-COLLECT with three frames queued.
    for (int i = 0; i < 3; i++) begin
      strobe(3'b111, 16'h4000 + 16'(i), 16'h5000 + 16'(i), 16'h6000 + 16'(i));
      tick();
    end
    strobe(3'b001, 16'h4444, 16'h0, 16'h0);
    tick();
    #3 rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(bus.valid_out), 64'd0);
    check("arst_fill",  64'(bus.fill_level), 64'd0);
    check("arst_frame", 64'(bus.frame_out), 64'd0);
    check("arst_ovf",   64'(bus.overflow_count), 64'd0);
    exp_q.delete();
    #2 rst_n = 1'b1;
    tick();
    strobe(3'b010, 16'h0, 16'h7777, 16'h0);
    tick();
    strobe(3'b100, 16'h0, 16'h0, 16'h8888);
    repeat (3) tick();
    check("arst_no_stale", 64'(bus.valid_out), 64'd0);
    strobe(3'b001, 16'h9999, 16'h0, 16'h0);
    tick();
    push_exp(3'b000, 16'h8888, 16'h7777, 16'h9999);
    check_head("arst_fresh");
    bus.ready_in = 1'b1;
    tick();
    check("final_empty", 64'(bus.valid_out), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
